// File: rtl/estimation_sequencer_mc.sv
// rtl/estimation_sequencer_mc.sv - multi-channel linearize/estimate/decide stage sequencer
// Walks the enabled channels in ascending order, running three handshaked stages per channel.
`timescale 1ns/1ps
module estimation_sequencer_mc #(
  parameter int N   = 32,
  parameter int CH  = 2,
  parameter int TMO = 1023
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [CH-1:0]   ch_en_i,
  input  logic [CH*N-1:0] i_in_i,
  input  logic [N-1:0]    exp_i,
  output logic            lin_start_o,
  output logic            est_start_o,
  output logic            des_start_o,
  input  logic            lin_ack_i,
  input  logic            est_ack_i,
  input  logic            des_ack_i,
  output logic [N-1:0]    lin_x_o,
  input  logic [N-1:0]    lin_result_i,
  input  logic [N-1:0]    des_result_i,
  output logic [N-1:0]    est_y_o,
  output logic [2:0]      ch_sel_o,
  output logic            clear_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [CH*N-1:0] result_o,
  output logic [CH-1:0]   valid_o,
  output logic [CH-1:0]   err_o
);
  localparam int CW = $clog2(TMO + 1);

  typedef enum logic [3:0] {
    IDLE, CLR, LIN_REQ, LIN_WAIT, EST_REQ, EST_WAIT,
    DES_REQ, DES_WAIT, STORE, NEXT, FIN
  } state_t;

  state_t          state_q, state_d;
  logic [CH-1:0]   en_q, en_d;
  logic [2:0]      ch_q, ch_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    lin_x_q, lin_x_d, est_y_q, est_y_d;
  logic [CH*N-1:0] result_q, result_d;
  logic [CH-1:0]   valid_q, valid_d, err_q, err_d;
  logic            clear_q, clear_d, lin_start_q, lin_start_d;
  logic            est_start_q, est_start_d, des_start_q, des_start_d;
  logic            busy_q, busy_d, done_q, done_d;

  logic            first_found, next_found, wait_ack;
  logic [2:0]      first_idx, next_idx;
  logic [N:0]      sum_w;
  logic [N-1:0]    sat_w;

  // Descending scan so the last hit is the lowest qualifying channel.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int k = CH - 1; k >= 0; k--) begin
      if (en_q[k]) begin
        first_found = 1'b1;
        first_idx   = 3'(k);
      end
      if (en_q[k] && (k > int'(ch_q))) begin
        next_found = 1'b1;
        next_idx   = 3'(k);
      end
    end
  end

  // One guard bit detects signed overflow of LIN_RESULT + EXP.
  always_comb begin
    sum_w = {lin_result_i[N-1], lin_result_i} + {exp_i[N-1], exp_i};
    if (sum_w[N] != sum_w[N-1]) begin
      sat_w = sum_w[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end else begin
      sat_w = sum_w[N-1:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    lin_x_d  = lin_x_q;
    est_y_d  = est_y_q;
    result_d = result_q;
    valid_d  = valid_q;
    err_d    = err_q;
    wait_ack = 1'b0;
    case (state_q)
      LIN_WAIT: wait_ack = lin_ack_i;
      EST_WAIT: wait_ack = est_ack_i;
      DES_WAIT: wait_ack = des_ack_i;
      default:  wait_ack = 1'b0;
    endcase
    case (state_q)
      IDLE: begin
        if (start_i) begin
          en_d    = ch_en_i;
          state_d = CLR;
        end
      end
      CLR: begin
        valid_d = '0;
        err_d   = '0;
        if (first_found) begin
          ch_d    = first_idx;
          state_d = LIN_REQ;
        end else begin
          state_d = FIN;
        end
      end
      LIN_REQ: begin
        cnt_d   = '0;
        state_d = LIN_WAIT;
      end
      EST_REQ: begin
        cnt_d   = '0;
        state_d = EST_WAIT;
      end
      DES_REQ: begin
        cnt_d   = '0;
        state_d = DES_WAIT;
      end
      LIN_WAIT, EST_WAIT, DES_WAIT: begin
        if (wait_ack) begin
          case (state_q)
            LIN_WAIT: begin
              est_y_d = sat_w;
              state_d = EST_REQ;
            end
            EST_WAIT: state_d = DES_REQ;
            default: begin
              for (int k = 0; k < CH; k++) begin
                if (k == int'(ch_q)) begin
                  result_d[k*N +: N] = des_result_i;
                  valid_d[k]         = 1'b1;
                end
              end
              state_d = STORE;
            end
          endcase
        end else if (cnt_q == CW'(TMO - 1)) begin
          for (int k = 0; k < CH; k++) begin
            if (k == int'(ch_q)) err_d[k] = 1'b1;
          end
          state_d = NEXT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STORE: state_d = NEXT;
      NEXT: begin
        if (next_found) begin
          ch_d    = next_idx;
          state_d = LIN_REQ;
        end else begin
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Sample is captured on the way into LIN_REQ so LIN_X is stable alongside LIN_START.
    if (state_d == LIN_REQ) begin
      for (int k = 0; k < CH; k++) begin
        if (k == int'(ch_d)) lin_x_d = i_in_i[k*N +: N];
      end
    end
    clear_d     = (state_d == CLR);
    lin_start_d = (state_d == LIN_REQ);
    est_start_d = (state_d == EST_REQ);
    des_start_d = (state_d == DES_REQ);
    done_d      = (state_d == FIN);
    busy_d      = (state_d != IDLE) && (state_d != FIN);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      en_q        <= '0;
      ch_q        <= '0;
      cnt_q       <= '0;
      lin_x_q     <= '0;
      est_y_q     <= '0;
      result_q    <= '0;
      valid_q     <= '0;
      err_q       <= '0;
      clear_q     <= 1'b0;
      lin_start_q <= 1'b0;
      est_start_q <= 1'b0;
      des_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      ch_q        <= ch_d;
      cnt_q       <= cnt_d;
      lin_x_q     <= lin_x_d;
      est_y_q     <= est_y_d;
      result_q    <= result_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      clear_q     <= clear_d;
      lin_start_q <= lin_start_d;
      est_start_q <= est_start_d;
      des_start_q <= des_start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign lin_start_o = lin_start_q;
  assign est_start_o = est_start_q;
  assign des_start_o = des_start_q;
  assign lin_x_o     = lin_x_q;
  assign est_y_o     = est_y_q;
  assign ch_sel_o    = ch_q;
  assign clear_o     = clear_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign result_o    = result_q;
  assign valid_o     = valid_q;
  assign err_o       = err_q;
endmodule

// File: tb/tb_estimation_sequencer_mc.sv
// tb/tb_estimation_sequencer_mc.sv - randomized self-checking bench for estimation_sequencer_mc
`timescale 1ns/1ps
module tb_estimation_sequencer_mc;
  localparam int N   = 32;
  localparam int CH  = 2;
  localparam int TMO = 15;

  logic            clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [CH-1:0]   ch_en = '0;
  logic [CH*N-1:0] i_in = '0;
  logic [N-1:0]    exp_in = '0, lin_result = '0, des_result = '0;
  logic [2:0]      ack = '0;
  logic            lin_start, est_start, des_start, clear, busy, done;
  logic [N-1:0]    lin_x, est_y;
  logic [2:0]      ch_sel;
  logic [CH*N-1:0] result;
  logic [CH-1:0]   valid, err;

  int n_tests = 0, n_fail = 0, cyc = 0;
  logic [N-1:0] lin_res [CH];
  logic [N-1:0] des_res [CH];
  logic [N-1:0] mdl_res [CH];
  int dl [CH][3];
  int rem [3];
  bit early_lin = 1'b0;
  int exp_q [$];
  int cur_ch = 0, t_lin = 0, t_est = 0, n_lin = 0, n_done = 0;

  estimation_sequencer_mc #(.N(N), .CH(CH), .TMO(TMO)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .ch_en_i(ch_en), .i_in_i(i_in),
    .exp_i(exp_in), .lin_start_o(lin_start), .est_start_o(est_start),
    .des_start_o(des_start), .lin_ack_i(ack[0]), .est_ack_i(ack[1]),
    .des_ack_i(ack[2]), .lin_x_o(lin_x), .lin_result_i(lin_result),
    .des_result_i(des_result), .est_y_o(est_y), .ch_sel_o(ch_sel),
    .clear_o(clear), .busy_o(busy), .done_o(done), .result_o(result),
    .valid_o(valid), .err_o(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [N-1:0] sat_add(input logic [N-1:0] a, input logic [N-1:0] b);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
    if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
    return s[N-1:0];
  endfunction

  // Stage responder: ack arrives dl cycles after the start pulse, held one cycle.
  initial begin
    rem = '{0, 0, 0};
    forever begin
      @(negedge clk);
      if (rst) begin
        rem = '{0, 0, 0};
        ack = '0;
      end else begin
        for (int s = 0; s < 3; s++) begin
          if ((s == 0 && lin_start) || (s == 1 && est_start) || (s == 2 && des_start)) begin
            rem[s] = dl[ch_sel][s];
            ack[s] = (s == 0) && early_lin;
            if (s == 0) lin_result = lin_res[ch_sel];
            if (s == 2) des_result = des_res[ch_sel];
          end else if (rem[s] > 0) begin
            rem[s]--;
            ack[s] = (rem[s] == 0);
          end else begin
            ack[s] = 1'b0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (lin_start || est_start || des_start)
        chk("start_onehot", $countones({lin_start, est_start, des_start}), 1);
      if (lin_start) begin
        n_lin++;
        if (exp_q.size() == 0) chk("ch_order_extra", 1, 0);
        else begin
          cur_ch = exp_q.pop_front();
          chk("ch_sel", ch_sel, cur_ch);
        end
        chk("lin_x", lin_x, i_in[cur_ch*N +: N]);
        t_lin = cyc;
      end
      if (est_start) begin
        chk("est_y", est_y, sat_add(lin_res[cur_ch], exp_in));
        chk("lin_latency", cyc - t_lin, dl[cur_ch][0] + 1);
        t_est = cyc;
      end
      if (des_start) chk("est_latency", cyc - t_est, dl[cur_ch][1] + 1);
      if (done) begin
        n_done++;
        chk("busy_at_done", busy, 0);
      end
    end
  end

  task automatic set_dl(input int k, input int a, input int b, input int c);
    dl[k][0] = a; dl[k][1] = b; dl[k][2] = c;
  endtask

  task automatic run_frame(input logic [CH-1:0] en, input logic [N-1:0] e, input bit hold);
    logic [CH-1:0] xv, xe;
    logic [CH*N-1:0] xr;
    int t, last, lin0, done0, cnt;
    xv = '0; xe = '0; last = -1; cnt = 0;
    exp_q.delete();
    for (int k = 0; k < CH; k++) begin
      if (en[k]) begin
        exp_q.push_back(k);
        last = k;
        cnt++;
        if (dl[k][0] > TMO || dl[k][1] > TMO || dl[k][2] > TMO) xe[k] = 1'b1;
        else begin
          xv[k] = 1'b1;
          mdl_res[k] = des_res[k];
        end
      end
    end
    for (int k = 0; k < CH; k++) xr[k*N +: N] = mdl_res[k];
    lin0 = n_lin; done0 = n_done;
    @(negedge clk); ch_en = en; exp_in = e; start = 1'b1;
    @(negedge clk); chk("clear_c1", clear, 1); chk("busy_c1", busy, 1);
    if (!hold) start = 1'b0;
    @(negedge clk); chk("clear_c2", clear, 0); chk("lin_start_c2", lin_start, en != 0);
    t = 0;
    while (!done && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("frame_bound", t < 3000, 1);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("valid", valid, xv);
    chk("err", err, xe);
    chk("result", result, xr);
    chk("done_count", n_done - done0, 1);
    chk("lin_count", n_lin - lin0, cnt);
    chk("busy_idle", busy, 0);
    if (last >= 0) chk("ch_sel_final", ch_sel, last);
  endtask

  initial begin
    int t, done0;
    logic [CH-1:0] en;
    for (int k = 0; k < CH; k++) begin
      set_dl(k, 1, 1, 1);
      lin_res[k] = '0; des_res[k] = '0; mdl_res[k] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_result", result, 0); chk("rst_valid", valid, 0); chk("rst_err", err, 0);
    chk("rst_strobes", {clear, lin_start, est_start, des_start, busy, done}, 0);
    chk("rst_data", {est_y, lin_x, ch_sel}, 0);
    rst = 1'b0;

    for (int k = 0; k < CH; k++) begin lin_res[k] = 32'd10; des_res[k] = 32'h1234; end
    i_in = {32'hAAAA_0001, 32'h5555_0000};
    run_frame(2'b11, 32'd5, 1'b0);
    chk("est_y_basic", est_y, 32'd15);

    lin_res[0] = 32'h7FFF_FFF0;
    run_frame(2'b01, 32'h20, 1'b0);
    chk("est_y_pos_sat", est_y, 32'h7FFF_FFFF);
    lin_res[0] = 32'h8000_0000;
    run_frame(2'b01, 32'hFFFF_FFFF, 1'b0);
    chk("est_y_neg_sat", est_y, 32'h8000_0000);

    des_res[0] = 32'hDEAD_0000; des_res[1] = 32'h0000_BEEF;
    run_frame(2'b10, 32'd1, 1'b0);
    run_frame(2'b00, 32'd1, 1'b0);

    set_dl(0, 1, 1000, 1);
    run_frame(2'b11, 32'd3, 1'b0);
    set_dl(0, 15, 2, 3);
    run_frame(2'b01, 32'd3, 1'b0);
    set_dl(0, 16, 1, 1); set_dl(1, 2, 3, 16);
    run_frame(2'b11, 32'd3, 1'b0);

    set_dl(0, 1, 1, 1000); set_dl(1, 1, 1, 1);
    exp_q.delete(); exp_q.push_back(0);
    @(negedge clk); ch_en = 2'b01; start = 1'b1;
    @(negedge clk); start = 1'b0;
    t = 0;
    while (!des_start && t < 200) begin @(negedge clk); t++; end
    chk("abort_reach_des", t < 200, 1);
    repeat (3) @(negedge clk);
    done0 = n_done; rst = 1'b1;
    @(negedge clk);
    chk("abort_result", result, 0); chk("abort_valid", valid, 0); chk("abort_err", err, 0);
    chk("abort_strobes", {clear, lin_start, est_start, des_start, busy, done}, 0);
    chk("abort_data", {est_y, lin_x, ch_sel}, 0);
    rst = 1'b0;
    for (int k = 0; k < CH; k++) mdl_res[k] = '0;
    repeat (5) @(negedge clk);
    chk("abort_no_done", n_done - done0, 0);
    set_dl(0, 1, 1, 1);
    run_frame(2'b11, 32'd7, 1'b0);

    early_lin = 1'b1;
    run_frame(2'b11, 32'd9, 1'b1);
    early_lin = 1'b0;

    for (int f = 0; f < 20; f++) begin
      for (int k = 0; k < CH; k++) begin
        for (int s = 0; s < 3; s++) begin
          t = int'($urandom_range(0, 11));
          dl[k][s] = (t == 0) ? 16 : (t == 1) ? 15 : int'($urandom_range(1, 4));
        end
        lin_res[k] = $urandom;
        des_res[k] = $urandom;
      end
      i_in = {$urandom, $urandom};
      en = 2'($urandom_range(0, 3));
      run_frame(en, ($urandom_range(0, 3) == 0) ? 32'h7FFF_0000 : $urandom, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/estimation_sequencer_mc.md
ESTIMATION_SEQUENCER_MC -- requirements
Module: estimation_sequencer_mc

Interface
REQ-001 Parameter N, default 32, data word width in bits; SHALL be at least 8.
REQ-002 Parameter CH, default 2, number of channels; SHALL be in the range 1..8.
REQ-003 Parameter TMO, default 1023, the maximum number of wait cycles allowed per stage acknowledge.
REQ-004 CLK  in  1  is the single clock; all logic SHALL be on the rising edge.
REQ-005 RST  in  1  is the reset: synchronous, active-high.
REQ-006 START  in  1  requests a frame.
REQ-007 CH_EN  in  CH  is the channel enable mask, sampled at frame accept.
REQ-008 I_IN  in  CH*N  carries the packed signed samples; channel k occupies bits [k*N +: N].
REQ-009 EXP  in  N  is the signed offset added to the linearizer result.
REQ-010 LIN_START/EST_START/DES_START  out  1 each  are the stage start pulses.
REQ-011 LIN_ACK/EST_ACK/DES_ACK  in  1 each  are the stage completion flags.
REQ-012 LIN_X  out  N  is the sample sent to the linearizer.
REQ-013 LIN_RESULT  in  N  and  DES_RESULT  in  N  are the stage results.
REQ-014 EST_Y  out  N  is the saturated sum sent to the estimator.
REQ-015 CH_SEL  out  3  is the index of the active channel.
REQ-016 CLEAR  out  1  clears the stage datapaths.
REQ-017 BUSY  out  1  indicates a frame is in progress.
REQ-018 DONE  out  1  is the frame-complete pulse.
REQ-019 RESULT  out  CH*N  holds the per-channel final results.
REQ-020 VALID  out  CH  holds the per-channel result-valid flags.
REQ-021 ERR  out  CH  holds the per-channel timeout flags.

Function
REQ-022 The FSM SHALL have the states IDLE, CLR, LIN_REQ, LIN_WAIT, EST_REQ, EST_WAIT, DES_REQ, DES_WAIT, STORE, NEXT and FIN.
REQ-023 In IDLE, START=1 SHALL latch CH_EN, set BUSY and go to CLR; START SHALL be ignored in every other state.
REQ-024 CLR SHALL drive CLEAR=1 for exactly one cycle, clear VALID and ERR, and select the lowest enabled channel.
  - If no channel is enabled, CLR SHALL go directly to FIN.
REQ-025 LIN_REQ SHALL register LIN_X with the I_IN slice of CH_SEL and pulse LIN_START for one cycle.
  - EST_REQ SHALL pulse EST_START for one cycle.
  - DES_REQ SHALL pulse DES_START for one cycle.
REQ-026 The *_WAIT states SHALL sample their ACK input starting the cycle after the REQ state; an ACK already high during the REQ cycle SHALL be ignored.
REQ-027 On LIN_ACK=1 in LIN_WAIT, EST_Y SHALL be registered as the signed saturated sum LIN_RESULT+EXP.
  - Positive overflow SHALL give 0111...1.
  - Negative overflow SHALL give 1000...0.
  - Otherwise EST_Y SHALL be the plain sum.
REQ-028 On DES_ACK=1, STORE SHALL write DES_RESULT into the RESULT slice of CH_SEL and set VALID[CH_SEL].
REQ-029 A wait counter SHALL reset on entry to each *_WAIT state; if it reaches TMO with no ACK, the FSM SHALL set ERR[CH_SEL], leave VALID[CH_SEL]=0, and go to NEXT.
REQ-030 NEXT SHALL advance CH_SEL to the next higher enabled channel and go to LIN_REQ; if no enabled channel remains, it SHALL go to FIN.
REQ-031 FIN SHALL pulse DONE for one cycle, clear BUSY and return to IDLE.
REQ-032 RESULT slices of channels that are disabled or timed out SHALL retain their previous values.
REQ-033 Minimum latency with single-cycle acks SHALL be: START in cycle 0, CLEAR in cycle 1, LIN_START in cycle 2.
REQ-034 All outputs SHALL be registered.
REQ-035 At most one *_START output SHALL be high in any cycle.

Reset
REQ-036 RST=1 SHALL force IDLE and zero all outputs (RESULT, VALID, ERR, EST_Y, LIN_X, CH_SEL, strobes, BUSY) on the next edge, including when asserted mid-frame.
REQ-037 RST SHALL take priority over START and over every ACK in the same cycle.
REQ-038 No DONE pulse SHALL be produced for a frame that is aborted by RST.

Verification
REQ-039 Scenario: CH=2, CH_EN=11, EXP=5, LIN_RESULT=10, DES_RESULT=0x1234 with each ACK 1 cycle after its START -> expect EST_Y=15, RESULT={0x1234,0x1234}, VALID=11, a single DONE pulse, ERR=00.
REQ-040 Scenario: LIN_RESULT=0x7FFFFFF0, EXP=0x20 -> expect EST_Y=0x7FFFFFFF; then LIN_RESULT=0x80000000, EXP=0xFFFFFFFF -> expect EST_Y=0x80000000.
REQ-041 Scenario: CH_EN=10 -> expect only channel 1 processed, CH_SEL=1, VALID=10, RESULT[0] unchanged.
  - Then CH_EN=00 -> expect CLEAR, DONE and no stage START.
REQ-042 Scenario: TMO=15, EST_ACK never asserted on channel 0 -> expect ERR=01 after 15 wait cycles, channel 1 still completes, VALID=10.
REQ-043 Scenario: RST asserted in DES_WAIT -> expect all outputs zero on the next edge, no DONE; a following START restarts the frame normally.
REQ-044 Scenario: START held high for the whole frame -> expect exactly one frame.
  - LIN_ACK held high through LIN_REQ -> expect the early ack ignored and acceptance on the first LIN_WAIT cycle.
